// File: rtl/data_memory_responder_if.sv
// Data-memory request/response bus between the MEM stage and its responder.
// Latency: n/a (signal bundle only).
// Backpressure: responder drives ready low while a request is outstanding.
interface data_memory_responder_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        done_pulse;
`ifdef DATA_MEMORY_ERROR_EN
    logic        access_error;

    modport master (
        output mem_r_en, mem_w_en, address, write_data,
        input  read_data, ready, done_pulse, access_error
    );

    modport slave (
        input  mem_r_en, mem_w_en, address, write_data,
        output read_data, ready, done_pulse, access_error
    );
`else
    modport master (
        output mem_r_en, mem_w_en, address, write_data,
        input  read_data, ready, done_pulse
    );

    modport slave (
        input  mem_r_en, mem_w_en, address, write_data,
        output read_data, ready, done_pulse
    );
`endif
endinterface

// File: rtl/data_memory_responder.sv
// Behavioural data-memory responder for the MEM stage (internal word array, IDLE/BUSY/DONE FSM).
// Latency: request seen in IDLE -> WAIT_CYCLES BUSY cycles -> DONE; access happens on the BUSY->DONE edge.
// Backpressure: ready=0 while a request is pending in IDLE or during BUSY. Optional access_error via DATA_MEMORY_ERROR_EN.
module data_memory_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 4,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    data_memory_responder_if.slave   bus
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic        lat_wr;
    logic        req;
    logic [31:0] word_idx;
    logic        in_range;
    logic        access_fire;

    logic [31:0] mem [DEPTH];

    assign req = bus.mem_r_en | bus.mem_w_en;

    // Index is derived from the latched address so mid-access input changes cannot disturb it;
    // subtraction wraps for addresses below the base, which the >= test rejects.
    assign word_idx    = (lat_addr - 32'(BASE_ADDR)) >> 2;
    assign in_range    = (lat_addr >= 32'(BASE_ADDR)) && (word_idx < 32'(DEPTH));
    assign access_fire = (state == BUSY) && (cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: requests are only sampled in IDLE; DONE always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = BUSY;
            BUSY:    if (cnt == LAST_CNT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: stall while a request is pending or being serviced.
    always_comb begin
        bus.ready      = 1'b1;
        bus.done_pulse = 1'b0;
        case (state)
            IDLE:    bus.ready = ~req;
            BUSY:    bus.ready = 1'b0;
            DONE:    bus.done_pulse = 1'b1;
            default: bus.ready = 1'b1;
        endcase
    end

    // Wait counter, request capture and load result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt           <= 4'd0;
            lat_addr      <= 32'd0;
            lat_data      <= 32'd0;
            lat_wr        <= 1'b0;
            bus.read_data <= 32'd0;
        end else begin
            if (state == IDLE && req) begin
                cnt      <= 4'd0;
                lat_addr <= bus.address;
                lat_data <= bus.write_data;
                // A simultaneous read+write is serviced as a write.
                lat_wr   <= bus.mem_w_en;
            end else if (state == BUSY) begin
                cnt <= cnt + 4'd1;
            end
            if (access_fire && !lat_wr) begin
                bus.read_data <= in_range ? mem[word_idx[IDX_W-1:0]] : 32'd0;
            end
        end
    end

    // Word array write port; contents deliberately survive reset, and an aborted access never fires.
    always_ff @(posedge clk) begin
        if (access_fire && lat_wr && in_range) begin
            mem[word_idx[IDX_W-1:0]] <= lat_data;
        end
    end

`ifdef DATA_MEMORY_ERROR_EN
    logic lat_both;

    // Remember whether the sampled request asked for both read and write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_both <= 1'b0;
        end else if (state == IDLE && req) begin
            lat_both <= bus.mem_r_en & bus.mem_w_en;
        end
    end

    // Error flag is valid only in the DONE cycle, zero otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.access_error <= 1'b0;
        end else begin
            bus.access_error <= access_fire && (!in_range || lat_both);
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: table of accesses plus reset-abort and mid-BUSY-change sequences.
// Latency: expects 5 stall cycles then a DONE cycle (default WAIT_CYCLES=4).
// Backpressure: initiator holds its request until ready=1, then drops it.
module tb_data_memory_responder;

    localparam int EXP_STALL = 5;

    logic clk;
    logic rst_n;

    data_memory_responder_if bus ();

    data_memory_responder #(
        .DEPTH       (64),
        .WAIT_CYCLES (4),
        .BASE_ADDR   (1024)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at posedge+1; drives one request and waits for ready, optionally changing
    // address/data after the first edge (while the responder is BUSY).
    task automatic run_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic chg, input logic [31:0] ca, input logic [31:0] cd,
                              output int stall, output logic early_done, output logic done_at_ready,
                              output logic [31:0] rd, output logic err);
        bus.mem_r_en   = r;
        bus.mem_w_en   = w;
        bus.address    = a;
        bus.write_data = d;
        stall = 0; early_done = 1'b0; done_at_ready = 1'b0; rd = 32'd0; err = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                done_at_ready = bus.done_pulse;
                rd = bus.read_data;
`ifdef DATA_MEMORY_ERROR_EN
                err = bus.access_error;
`endif
                break;
            end
            stall++;
            if (bus.done_pulse) early_done = 1'b1;
            @(posedge clk);
            #1;
            if (chg) begin
                bus.address    = ca;
                bus.write_data = cd;
            end
        end
        @(posedge clk);
        #1;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
    endtask

    task automatic access_chk(input string name, input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic chg, input logic [31:0] ca,
                              input logic [31:0] cd, input logic [31:0] exp_rd, input logic exp_err);
        int          stall;
        logic        early, dn, err;
        logic [31:0] rd;
        run_access(r, w, a, d, chg, ca, cd, stall, early, dn, rd, err);
        chk({name, " stall"}, 32'(stall), 32'(EXP_STALL));
        chk({name, " done_pulse"}, {31'd0, dn}, 32'd1);
        chk({name, " early_done"}, {31'd0, early}, 32'd0);
        chk({name, " read_data"}, rd, exp_rd);
`ifdef DATA_MEMORY_ERROR_EN
        chk({name, " access_error"}, {31'd0, err}, {31'd0, exp_err});
`else
        if (err !== 1'b0 && exp_err === 1'b0) chk({name, " err"}, {31'd0, err}, 32'd0);
`endif
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation timeout, got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic seen;

        //           rd    wr    addr   wdata          exp_rdata      err
        vecs[0]  = mk(1'b0, 1'b1, 1024, 32'hDEADBEEF, 32'h00000000, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1024, 32'h0,        32'hDEADBEEF, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 1028, 32'h11,       32'hDEADBEEF, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 1032, 32'h22,       32'hDEADBEEF, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 1028, 32'h0,        32'h00000011, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 1032, 32'h0,        32'h00000022, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 1000, 32'h0,        32'h00000000, 1'b1);
        vecs[7]  = mk(1'b1, 1'b0, 1280, 32'h0,        32'h00000000, 1'b1);
        vecs[8]  = mk(1'b0, 1'b1, 1280, 32'h99,       32'h00000000, 1'b1);
        vecs[9]  = mk(1'b0, 1'b1, 1276, 32'h12345678, 32'h00000000, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 1276, 32'h0,        32'h12345678, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 1024, 32'h0,        32'hDEADBEEF, 1'b0);
        vecs[12] = mk(1'b1, 1'b1, 1036, 32'h5A5A,     32'hDEADBEEF, 1'b1);
        vecs[13] = mk(1'b1, 1'b0, 1036, 32'h0,        32'h00005A5A, 1'b0);
        vecs[14] = mk(1'b1, 1'b0, 1031, 32'h0,        32'h00000011, 1'b0);

        rst_n          = 1'b0;
        bus.mem_r_en   = 1'b0;
        bus.mem_w_en   = 1'b0;
        bus.address    = 32'd0;
        bus.write_data = 32'd0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", {31'd0, bus.ready}, 32'd1);
        chk("reset done_pulse", {31'd0, bus.done_pulse}, 32'd0);
        chk("reset read_data", bus.read_data, 32'd0);
`ifdef DATA_MEMORY_ERROR_EN
        chk("reset access_error", {31'd0, bus.access_error}, 32'd0);
`endif
        bus.mem_w_en = 1'b1;
        #1;
        chk("reset ready with req", {31'd0, bus.ready}, 32'd0);
        bus.mem_w_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven accesses, issued back-to-back.
        for (int i = 0; i < 15; i++) begin
            access_chk($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                       1'b0, 32'd0, 32'd0, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // done_pulse lasts one cycle only; read_data holds.
        @(negedge clk);
        chk("post done_pulse", {31'd0, bus.done_pulse}, 32'd0);
        chk("post ready", {31'd0, bus.ready}, 32'd1);
        chk("hold read_data", bus.read_data, 32'h11);
        @(posedge clk);
        #1;

        // Reset in the 2nd BUSY cycle of a write aborts it.
        access_chk("prior wr 1040", 1'b0, 1'b1, 1040, 32'h33, 1'b0, 32'd0, 32'd0, 32'h11, 1'b0);
        bus.mem_w_en   = 1'b1;
        bus.address    = 1040;
        bus.write_data = 32'h77;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort ready with req", {31'd0, bus.ready}, 32'd0);
        chk("abort read_data", bus.read_data, 32'd0);
        bus.mem_w_en = 1'b0;
        #1;
        chk("abort ready idle", {31'd0, bus.ready}, 32'd1);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done_pulse) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.done_pulse) seen = 1'b1;
        end
        chk("abort no done_pulse", {31'd0, seen}, 32'd0);
        @(posedge clk);
        #1;
        access_chk("read 1040 after abort", 1'b1, 1'b0, 1040, 32'd0, 1'b0, 32'd0, 32'd0, 32'h33, 1'b0);

        // Inputs changed mid-BUSY are ignored.
        access_chk("prior wr 1048", 1'b0, 1'b1, 1048, 32'h44, 1'b0, 32'd0, 32'd0, 32'h33, 1'b0);
        access_chk("wr 1044 changed", 1'b0, 1'b1, 1044, 32'hAA, 1'b1, 1048, 32'hBB, 32'h33, 1'b0);
        access_chk("read 1044", 1'b1, 1'b0, 1044, 32'd0, 1'b0, 32'd0, 32'd0, 32'hAA, 1'b0);
        access_chk("read 1048", 1'b1, 1'b0, 1048, 32'd0, 1'b0, 32'd0, 32'd0, 32'h44, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the MEM-stage data-memory interface. The MEM stage issues a single read or write request and holds it stable. This block services the request after a fixed number of wait states.
- While a request is outstanding it drives `ready` low, which the top level uses to freeze the pipeline.
- Word storage is internal (register array). This is the behavioural stand-in for the off-chip SRAM behind the MEM stage.

Parameters:
- DEPTH, 64: number of 32-bit words stored.
- WAIT_CYCLES, 4: number of BUSY cycles per access. Legal range is 1 to 15.
- BASE_ADDR, 1024: byte address that maps to word 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_r_en  input  1  read request. Held by the initiator until `ready`=1.
- mem_w_en  input  1  write request. Held by the initiator until `ready`=1.
- address  input  32  byte address. Bits [1:0] are ignored.
- write_data  input  32  store value.
- read_data  output  32  load result. Valid in the DONE cycle, then held.
- ready  output  1  0 means the initiator must stall.
- done_pulse  output  1  1 for exactly the DONE cycle.

Behaviour:
- req = mem_r_en | mem_w_en. If both are asserted, the access is treated as a write.
- Word index = (address - BASE_ADDR) >> 2, computed as 32-bit unsigned.
  - In range when address >= BASE_ADDR and index < DEPTH.
- State machine: IDLE, BUSY, DONE. Encoded state plus a 4-bit wait counter.
  - IDLE: if req, go to BUSY with cnt=0, and latch address, write_data and the write flag. Otherwise stay in IDLE.
  - BUSY: cnt increments each cycle. When cnt==WAIT_CYCLES-1, go to DONE and perform the access on that edge:
    - write: array[index] <= latched data.
    - read: read_data <= array[index].
  - DONE: go to IDLE unconditionally. A request still present in DONE is treated as already consumed. The next request is sampled only in IDLE.
- ready (combinational) = 0 when (state==IDLE and req) or state==BUSY. ready = 1 in DONE, and in IDLE when there is no request.
- Latency: a request first seen in cycle c0 gives ready=0 for c0..c(WAIT_CYCLES), and ready=1 plus done_pulse=1 in c(WAIT_CYCLES+1).
  - Default WAIT_CYCLES=4: the stall is 5 cycles and DONE is the 6th cycle.
- Back-to-back requests: the second request is seen in the IDLE cycle after DONE and starts a new 5-cycle stall. There is no overlap between accesses.
- Out-of-range access:
  - write is dropped and the array is unchanged;
  - read returns read_data=0;
  - timing is identical to an in-range access.
- Inputs changing during BUSY are ignored, because the address, data and write flag are latched in IDLE.
- read_data keeps its last load value through writes and idle cycles. It changes only when a read completes.
- Reset (rst=0, at any time, including mid-BUSY):
  - state=IDLE, cnt=0, read_data=0, done_pulse=0, latched registers cleared;
  - ready follows its IDLE rule (it is 0 if a request is already present);
  - an aborted write does not modify the array;
  - array contents are NOT cleared by reset.
- Outputs at reset: read_data=0, done_pulse=0, ready=1 when no request is present.

Optional Feature:
- Macro: DATA_MEMORY_ERROR_EN.
- Defined: adds output port `access_error` (1 bit). It is registered and asserted in the DONE cycle when either:
  - the access was out of range, or
  - both mem_r_en and mem_w_en were asserted in the sampling IDLE cycle.
  - It resets to 0 and is 0 in every other cycle.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then write 0xDEADBEEF to address 1024 -> ready=0 for 5 cycles, ready=1 and done_pulse=1 in cycle 6; then a read of 1024 -> read_data=0xDEADBEEF in its DONE cycle.
- Write 0x11 to 1028 and 0x22 to 1032 back-to-back, then read both -> each access stalls 5 cycles with one IDLE cycle between accesses; reads return 0x11 and 0x22; read_data holds 0x22 afterward.
- Read at address 1000 and at 1024+4*DEPTH (1280) -> read_data=0, normal 6-cycle timing; a write to 1280 leaves the array unchanged. With DATA_MEMORY_ERROR_EN, access_error=1 in DONE.
- mem_r_en=mem_w_en=1, address 1036, data 0x5A5A -> treated as a write; a later read of 1036 returns 0x5A5A. With DATA_MEMORY_ERROR_EN, access_error=1.
- Assert rst=0 in the 2nd BUSY cycle of a write of 0x77 to 1040 -> ready reflects IDLE immediately, done_pulse never pulses, and a later read of 1040 returns the prior contents, not 0x77.
- Change address and write_data mid-BUSY (1044/0xAA changed to 1048/0xBB) -> 0xAA is stored at 1044 and location 1048 is unchanged.
